// File: rtl/hazard_pkg.sv
// Shared types and default latencies for the ID-stage hazard scoreboard.
// Branch decisions arrive from EX as branch_ctrl_e.
package hazard_pkg;

  typedef enum logic [1:0] {
    PC4    = 2'b00,
    PCIMM  = 2'b01,
    IMMRS1 = 2'b10
  } branch_ctrl_e;

  localparam int DEF_NUM_REGS   = 32;
  localparam int DEF_ADDR_W     = 5;
  localparam int DEF_LOAD_LAT   = 1;
  localparam int DEF_MULDIV_LAT = 4;
  localparam int DEF_CNT_W      = 3;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage operand/destination info in, pipeline hold/flush controls out.
// master = pipeline side, slave = hazard scoreboard.
interface hazard_scoreboard_if
  import hazard_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);

  branch_ctrl_e      BranchCtrl;
  logic              id_valid;
  logic [ADDR_W-1:0] rs1_addr;
  logic [ADDR_W-1:0] rs2_addr;
  logic              rs1_used;
  logic              rs2_used;
  logic [ADDR_W-1:0] id_rd_addr;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              id_multicycle;
  logic              InstrFlush;
  logic              CtrlSignalFlush;
  logic              IFID_RegWrite;
  logic              PCWrite;
  logic              mdu_busy;
  logic [31:0]       stall_cycles;

  modport master (
    output BranchCtrl, id_valid,
    output rs1_addr, rs2_addr,
    output rs1_used, rs2_used,
    output id_rd_addr, id_reg_write,
    output id_mem_read, id_multicycle,
    input  InstrFlush, CtrlSignalFlush,
    input  IFID_RegWrite, PCWrite,
    input  mdu_busy, stall_cycles
  );

  modport slave (
    input  BranchCtrl, id_valid,
    input  rs1_addr, rs2_addr,
    input  rs1_used, rs2_used,
    input  id_rd_addr, id_reg_write,
    input  id_mem_read, id_multicycle,
    output InstrFlush, CtrlSignalFlush,
    output IFID_RegWrite, PCWrite,
    output mdu_busy, stall_cycles
  );

endinterface

// File: rtl/hazard_pend_timer.sv
// Countdown timer: load wins over decrement, holds at zero.
// Used per register and for the MUL/DIV busy window.
module hazard_pend_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Pending-write scoreboard: stalls ID consumers for the exact
// producer latency, stalls on a busy MUL/DIV, flushes on EX branches.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS   = DEF_NUM_REGS,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int LOAD_LAT   = DEF_LOAD_LAT,
  parameter int MULDIV_LAT = DEF_MULDIV_LAT,
  parameter int CNT_W      = DEF_CNT_W
) (
  input logic clk,
  input logic rst,
  hazard_scoreboard_if.slave bus
);

  logic [NUM_REGS-1:0] pend_nz;
  logic [NUM_REGS-1:1] pend_z;
  logic [CNT_W-1:0]    ld_val;
  logic                mdu_z;
  logic                br_taken;
  logic                raw;
  logic                strc;
  logic                stall;
  logic                issue;
  logic [31:0]         stall_cnt;

  assign br_taken = (bus.BranchCtrl != PC4);

  assign raw = bus.id_valid &
    ((bus.rs1_used & pend_nz[bus.rs1_addr]) |
     (bus.rs2_used & pend_nz[bus.rs2_addr]));

  assign strc  = bus.id_valid & bus.id_multicycle & ~mdu_z;
  assign stall = raw | strc;
  assign issue = bus.id_valid & ~stall & ~br_taken;

  // Non-load, non-MDU writers load 0: forwarding covers them.
  always_comb begin
    ld_val = '0;
    if (bus.id_multicycle)
      ld_val = CNT_W'(MULDIV_LAT);
    else if (bus.id_mem_read)
      ld_val = CNT_W'(LOAD_LAT);
  end

  assign pend_nz[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_pend
    hazard_pend_timer #(.W(CNT_W)) u_pend (
      .clk      (clk),
      .rst      (rst),
      .load     (issue & bus.id_reg_write &
                 (bus.id_rd_addr == ADDR_W'(r))),
      .load_val (ld_val),
      .zero     (pend_z[r])
    );
    assign pend_nz[r] = ~pend_z[r];
  end

  hazard_pend_timer #(.W(CNT_W)) u_mdu (
    .clk      (clk),
    .rst      (rst),
    .load     (issue & bus.id_multicycle),
    .load_val (CNT_W'(MULDIV_LAT)),
    .zero     (mdu_z)
  );

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (stall & ~br_taken & (stall_cnt != '1))
      stall_cnt <= stall_cnt + 32'd1;
  end

  assign bus.stall_cycles = stall_cnt;
  assign bus.mdu_busy     = ~rst & ~mdu_z;

  always_comb begin
    bus.InstrFlush      = 1'b0;
    bus.CtrlSignalFlush = 1'b0;
    bus.IFID_RegWrite   = 1'b1;
    bus.PCWrite         = 1'b1;
    unique case (1'b1)
      rst: ;
      (~rst & br_taken): begin
        bus.InstrFlush      = 1'b1;
        bus.CtrlSignalFlush = 1'b1;
      end
      (~rst & ~br_taken & stall): begin
        bus.CtrlSignalFlush = 1'b1;
        bus.IFID_RegWrite   = 1'b0;
        bus.PCWrite         = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed-vector bench for hazard_scoreboard; expectations queued
// by stimulus, popped and compared by a negedge monitor.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  typedef struct {
    string       nm;
    logic [4:0]  fl;
    logic [31:0] cnt;
  } exp_t;

  localparam logic [3:0] NRM = 4'b0011;
  localparam logic [3:0] STL = 4'b0100;
  localparam logic [3:0] FLS = 4'b1111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic chk_v = 1'b0;
  int   ncmp = 0;
  int   nerr = 0;
  exp_t q[$];

  hazard_scoreboard_if #(.ADDR_W(5)) bus ();

  hazard_scoreboard dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog expired");
  end

  always @(negedge clk) begin
    if (chk_v) begin
      if (q.size() == 0) begin
        ncmp++;
        nerr++;
        $display("FAIL monitor: got output, required queued expectation");
      end else begin
        exp_t e;
        logic [4:0] got;
        e = q.pop_front();
        got = {bus.InstrFlush, bus.CtrlSignalFlush,
               bus.IFID_RegWrite, bus.PCWrite, bus.mdu_busy};
        ncmp++;
        if (got !== e.fl || bus.stall_cycles !== e.cnt) begin
          nerr++;
          $display("FAIL %s: got flags=%b cnt=%0d required flags=%b cnt=%0d",
                   e.nm, got, bus.stall_cycles, e.fl, e.cnt);
        end
      end
    end
  end

  task automatic ins(input logic v,
                     input logic [4:0] r1, input logic [4:0] r2,
                     input logic u1, input logic u2,
                     input logic [4:0] rd, input logic rw,
                     input logic mr, input logic mc,
                     input branch_ctrl_e br);
    bus.id_valid      = v;
    bus.rs1_addr      = r1;
    bus.rs2_addr      = r2;
    bus.rs1_used      = u1;
    bus.rs2_used      = u2;
    bus.id_rd_addr    = rd;
    bus.id_reg_write  = rw;
    bus.id_mem_read   = mr;
    bus.id_multicycle = mc;
    bus.BranchCtrl    = br;
  endtask

  task automatic idle();
    ins(0, 0, 0, 0, 0, 0, 0, 0, 0, PC4);
  endtask

  task automatic chk(input string nm, input logic [3:0] f,
                     input logic busy, input int cnt);
    exp_t e;
    e.nm  = nm;
    e.fl  = {f, busy};
    e.cnt = 32'(cnt);
    q.push_back(e);
    chk_v = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    ins(1, 5, 0, 1, 0, 5, 1, 1, 0, PCIMM);
    @(posedge clk);
    #1;
    chk("rst_gates_branch", NRM, 0, 0);
    idle();
    chk("rst_state", NRM, 0, 0);
    rst = 1'b0;

    // load-use
    ins(1, 1, 0, 1, 0, 5, 1, 1, 0, PC4);
    chk("lw_issue", NRM, 0, 0);
    ins(1, 5, 1, 1, 1, 6, 1, 0, 0, PC4);
    chk("lu_stall", STL, 0, 0);
    chk("lu_release", NRM, 0, 1);

    // mul dependency
    ins(1, 1, 2, 1, 1, 7, 1, 0, 1, PC4);
    chk("mul_issue", NRM, 0, 1);
    ins(1, 7, 1, 1, 1, 8, 1, 0, 0, PC4);
    chk("mul_dep_s1", STL, 1, 1);
    chk("mul_dep_s2", STL, 1, 2);
    chk("mul_dep_s3", STL, 1, 3);
    chk("mul_dep_s4", STL, 1, 4);
    chk("mul_dep_go", NRM, 0, 5);

    // structural
    ins(1, 11, 12, 1, 1, 10, 1, 0, 1, PC4);
    chk("div1_issue", NRM, 0, 5);
    ins(1, 14, 15, 1, 1, 13, 1, 0, 1, PC4);
    chk("div2_s1", STL, 1, 5);
    chk("div2_s2", STL, 1, 6);
    chk("div2_s3", STL, 1, 7);
    chk("div2_s4", STL, 1, 8);
    chk("div2_go", NRM, 0, 9);
    idle();
    for (int i = 0; i < 4; i++) chk("div2_busy", NRM, 1, 9);

    // branch overrides load-use stall
    ins(1, 1, 0, 1, 0, 5, 1, 1, 0, PC4);
    chk("lw2_issue", NRM, 0, 9);
    ins(1, 5, 1, 1, 1, 6, 1, 0, 0, PCIMM);
    chk("br_over_stall", FLS, 0, 9);
    idle();
    chk("br_no_count", NRM, 0, 9);

    // x0 never pending / never stalls
    ins(1, 1, 0, 1, 0, 0, 1, 1, 0, PC4);
    chk("lw_x0", NRM, 0, 9);
    ins(1, 0, 0, 1, 1, 1, 1, 0, 0, PC4);
    chk("use_x0", NRM, 0, 9);
    ins(1, 1, 2, 1, 1, 9, 1, 0, 1, PC4);
    chk("mul_x9", NRM, 0, 9);
    ins(1, 0, 9, 1, 0, 3, 1, 0, 0, PC4);
    chk("addi_x0_rs2_unused", NRM, 1, 9);

    // rs1==rs2 both pending: single stall per cycle
    ins(1, 9, 9, 1, 1, 4, 1, 0, 0, PC4);
    chk("same_src_s1", STL, 1, 9);
    chk("same_src_s2", STL, 1, 10);
    chk("same_src_s3", STL, 1, 11);
    chk("same_src_go", NRM, 0, 12);

    // WAW: lw reloads pending mul rd with the shorter latency
    ins(1, 1, 2, 1, 1, 20, 1, 0, 1, PC4);
    chk("mul_x20", NRM, 0, 12);
    ins(1, 1, 0, 1, 0, 20, 1, 1, 0, PC4);
    chk("lw_x20", NRM, 1, 12);
    ins(1, 20, 1, 1, 1, 21, 1, 0, 0, PC4);
    chk("waw_s1", STL, 1, 12);
    chk("waw_go", NRM, 1, 13);
    idle();
    chk("waw_drain", NRM, 1, 13);

    // reset mid-stall
    ins(1, 1, 2, 1, 1, 7, 1, 0, 1, PC4);
    chk("mul3_issue", NRM, 0, 13);
    ins(1, 7, 1, 1, 1, 8, 1, 0, 0, PC4);
    chk("rst_mid_s1", STL, 1, 13);
    rst = 1'b1;
    chk("rst_mid_assert", NRM, 0, 14);
    rst = 1'b0;
    chk("rst_mid_after", NRM, 0, 0);

    chk_v = 1'b0;
    if (q.size() != 0) begin
      ncmp++;
      nerr++;
      $display("FAIL queue_drain: got %0d left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
